// File: rtl/ahb3lite_gpio.sv
// AHB3-Lite GPIO slave: 8 LED outputs (DATA_OUT with SET/CLR aliases) and 8 synchronized button inputs.
// Define GPIO_DEBOUNCE_EN to add a prescaled 3-sample debouncer in front of DATA_IN.
module ahb3lite_gpio #(
    parameter int g_haddr_width     = 32,
    parameter int g_hdata_width     = 32,
    parameter int g_debounce_cycles = 10000
) (
    input  logic                     hclk_i,
    input  logic                     hreset_n_i,
    input  logic                     hsel_i,
    input  logic [g_haddr_width-1:0] haddr_i,
    input  logic [1:0]               htrans_i,
    input  logic                     hwrite_i,
    input  logic [2:0]               hsize_i,
    input  logic [2:0]               hburst_i,
    input  logic [3:0]               hprot_i,
    input  logic                     hmastlock_i,
    input  logic [g_hdata_width-1:0] hwdata_i,
    input  logic                     hready_i,
    output logic [g_hdata_width-1:0] hrdata_o,
    output logic                     hreadyout_o,
    output logic                     hresp_o,
    input  logic [7:0]               gpio_i,
    output logic [7:0]               gpio_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam logic [1:0] REG_DATA_OUT = 2'd0;
    localparam logic [1:0] REG_DATA_IN  = 2'd1;
    localparam logic [1:0] REG_SET      = 2'd2;
    localparam logic [1:0] REG_CLR      = 2'd3;

    state_t      state_reg;
    logic        dp_valid_reg;
    logic        dp_write_reg;
    logic [1:0]  dp_addr_reg;
    logic [7:0]  data_out_reg;
    logic [7:0]  sync1_reg;
    logic [7:0]  sync2_reg;
    logic [7:0]  data_in;
    logic        addr_phase;
    logic        unmapped;
    logic        unused_inputs;

    assign addr_phase = hsel_i & hready_i & htrans_i[1];
    assign unmapped   = |haddr_i[g_haddr_width-1:4];
    assign gpio_o     = data_out_reg;

    assign unused_inputs = ^{hsize_i, hburst_i, hprot_i, hmastlock_i,
                             haddr_i[1:0], hwdata_i[g_hdata_width-1:8]};

    // Response FSM and data-phase bookkeeping; an unmapped transfer never reaches the register file.
    always_ff @(posedge hclk_i or negedge hreset_n_i) begin
        if (!hreset_n_i) begin
            state_reg    <= ST_IDLE;
            hreadyout_o  <= 1'b1;
            hresp_o      <= 1'b0;
            dp_valid_reg <= 1'b0;
            dp_write_reg <= 1'b0;
            dp_addr_reg  <= 2'd0;
            data_out_reg <= 8'h00;
        end else begin
            if (dp_valid_reg && dp_write_reg) begin
                case (dp_addr_reg)
                    REG_DATA_OUT: data_out_reg <= hwdata_i[7:0];
                    REG_SET:      data_out_reg <= data_out_reg | hwdata_i[7:0];
                    REG_CLR:      data_out_reg <= data_out_reg & ~hwdata_i[7:0];
                    default:      ;
                endcase
            end

            dp_valid_reg <= 1'b0;
            case (state_reg)
                ST_ERR1: begin
                    state_reg   <= ST_ERR2;
                    hreadyout_o <= 1'b1;
                    hresp_o     <= 1'b1;
                end
                default: begin
                    if (addr_phase && unmapped) begin
                        state_reg   <= ST_ERR1;
                        hreadyout_o <= 1'b0;
                        hresp_o     <= 1'b1;
                    end else begin
                        state_reg   <= ST_IDLE;
                        hreadyout_o <= 1'b1;
                        hresp_o     <= 1'b0;
                        if (addr_phase) begin
                            dp_valid_reg <= 1'b1;
                            dp_write_reg <= hwrite_i;
                            dp_addr_reg  <= haddr_i[3:2];
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge hclk_i or negedge hreset_n_i) begin
        if (!hreset_n_i) begin
            sync1_reg <= 8'h00;
            sync2_reg <= 8'h00;
        end else begin
            sync1_reg <= gpio_i;
            sync2_reg <= sync1_reg;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = (g_debounce_cycles > 2) ? $clog2(g_debounce_cycles) : 1;

    logic [CNT_W-1:0] prescale_reg;
    logic             tick;

    assign tick = (prescale_reg == CNT_W'(g_debounce_cycles - 1));

    always_ff @(posedge hclk_i or negedge hreset_n_i) begin
        if (!hreset_n_i) begin
            prescale_reg <= '0;
        end else if (tick) begin
            prescale_reg <= '0;
        end else begin
            prescale_reg <= prescale_reg + 1'b1;
        end
    end

    // Each bit keeps its two previous tick samples; three equal samples commit the new level.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_debounce
            logic [1:0] hist_reg;
            logic       bit_reg;

            always_ff @(posedge hclk_i or negedge hreset_n_i) begin
                if (!hreset_n_i) begin
                    hist_reg <= 2'b00;
                    bit_reg  <= 1'b0;
                end else if (tick) begin
                    hist_reg <= {hist_reg[0], sync2_reg[gi]};
                    if ({hist_reg, sync2_reg[gi]} == 3'b111) begin
                        bit_reg <= 1'b1;
                    end else if ({hist_reg, sync2_reg[gi]} == 3'b000) begin
                        bit_reg <= 1'b0;
                    end
                end
            end

            assign data_in[gi] = bit_reg;
        end
    endgenerate
`else
    assign data_in = sync2_reg;
`endif

    always_comb begin
        hrdata_o = '0;
        if (dp_valid_reg && !dp_write_reg) begin
            case (dp_addr_reg)
                REG_DATA_OUT: hrdata_o[7:0] = data_out_reg;
                REG_DATA_IN:  hrdata_o[7:0] = data_in;
                default:      ;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb3lite_gpio.sv
// Self-checking bench for ahb3lite_gpio: directed register/error/reset scenarios plus randomized
// AHB traffic compared every cycle against a transaction-level model of the register map.
module tb_ahb3lite_gpio;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b010;
    logic [2:0]  hburst = 3'b000;
    logic [3:0]  hprot = 4'b0011;
    logic        hmastlock = 1'b0;
    logic [31:0] hwdata = '0;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;
    logic [7:0]  gpio_in = 8'h00;
    logic [7:0]  gpio_out;

    always #5 clk = ~clk;
    assign hready = hreadyout;

    ahb3lite_gpio #(
        .g_haddr_width(32),
        .g_hdata_width(32),
        .g_debounce_cycles(N)
    ) dut (
        .hclk_i(clk),
        .hreset_n_i(rst_n),
        .hsel_i(hsel),
        .haddr_i(haddr),
        .htrans_i(htrans),
        .hwrite_i(hwrite),
        .hsize_i(hsize),
        .hburst_i(hburst),
        .hprot_i(hprot),
        .hmastlock_i(hmastlock),
        .hwdata_i(hwdata),
        .hready_i(hready),
        .hrdata_o(hrdata),
        .hreadyout_o(hreadyout),
        .hresp_o(hresp),
        .gpio_i(gpio_in),
        .gpio_o(gpio_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef enum {DP_NONE, DP_RD, DP_WR, DP_ERR1, DP_ERR2} dp_t;

    dp_t        m_dp = DP_NONE;
    logic [1:0] m_addr = 2'd0;
    logic [7:0] m_out = 8'h00;
    logic [7:0] m_h0 = 8'h00;
    logic [7:0] m_h1 = 8'h00;
    logic [7:0] m_smp [3];
    logic [7:0] m_db = 8'h00;
    int         m_edge = 0;

    function automatic logic [7:0] model_in();
`ifdef GPIO_DEBOUNCE_EN
        return m_db;
`else
        return m_h1;
`endif
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_dp = DP_NONE; m_addr = 2'd0; m_out = 8'h00;
            m_h0 = 8'h00; m_h1 = 8'h00; m_db = 8'h00; m_edge = 0;
            for (int i = 0; i < 3; i++) m_smp[i] = 8'h00;
        end else begin
            if (m_dp == DP_WR) begin
                if (m_addr == 2'd0) m_out = hwdata[7:0];
                else if (m_addr == 2'd2) m_out = m_out | hwdata[7:0];
                else if (m_addr == 2'd3) m_out = m_out & ~hwdata[7:0];
                $display("txn write addr=0x%0h data=0x%02h leds=0x%02h", {m_addr, 2'b00}, hwdata[7:0], m_out);
            end else if (m_dp == DP_RD) begin
                $display("txn read  addr=0x%0h", {m_addr, 2'b00});
            end else if (m_dp == DP_ERR2) begin
                $display("txn error response completed");
            end
            if (m_dp == DP_ERR1) begin
                m_dp = DP_ERR2;
            end else if (hsel && htrans[1]) begin
                if (haddr[31:4] != 28'h0) begin
                    m_dp = DP_ERR1;
                end else begin
                    m_dp = hwrite ? DP_WR : DP_RD;
                    m_addr = haddr[3:2];
                end
            end else begin
                m_dp = DP_NONE;
            end
            // Debounce: sample the 2-edge-delayed input every N edges; 3 equal samples commit.
            if (m_edge % N == N - 1) begin
                m_smp[2] = m_smp[1]; m_smp[1] = m_smp[0]; m_smp[0] = m_h1;
                for (int b = 0; b < 8; b++) begin
                    if (m_smp[0][b] && m_smp[1][b] && m_smp[2][b]) m_db[b] = 1'b1;
                    else if (!m_smp[0][b] && !m_smp[1][b] && !m_smp[2][b]) m_db[b] = 1'b0;
                end
            end
            m_h1 = m_h0;
            m_h0 = gpio_in;
            m_edge++;
        end
    end

    always @(negedge clk) begin
        logic        e_rdy, e_rsp;
        logic [31:0] e_rd;
        e_rdy = 1'b1; e_rsp = 1'b0; e_rd = 32'h0;
        if (rst_n) begin
            e_rdy = (m_dp != DP_ERR1);
            e_rsp = (m_dp == DP_ERR1) || (m_dp == DP_ERR2);
            if (m_dp == DP_RD) begin
                if (m_addr == 2'd0) e_rd = {24'h0, m_out};
                else if (m_addr == 2'd1) e_rd = {24'h0, model_in()};
            end
        end
        chk("cyc_hreadyout", {31'h0, hreadyout}, {31'h0, e_rdy});
        chk("cyc_hresp", {31'h0, hresp}, {31'h0, e_rsp});
        chk("cyc_hrdata", hrdata, e_rd);
        chk("cyc_gpio_o", {24'h0, gpio_out}, {24'h0, (rst_n ? m_out : 8'h00)});
    end

    // ---------------- stimulus ----------------
    logic        o_rdy, o_rsp;
    logic [31:0] o_rd;
    logic [7:0]  o_go;

    // Drives one address phase (plus hwdata for the previous transfer) and observes mid-cycle.
    task automatic cyc(input logic sel, input logic [1:0] tr, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd);
        hsel = sel; htrans = tr; hwrite = wr; haddr = a; hwdata = wd;
        @(negedge clk);
        o_rdy = hreadyout; o_rsp = hresp; o_rd = hrdata; o_go = gpio_out;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] wd);
        cyc(1'b0, 2'b00, 1'b0, 32'h0, wd);
    endtask

    task automatic reset_mid_cycle(input logic [31:0] wd);
        hsel = 1'b0; htrans = 2'b00; hwdata = wd;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_gpio", {24'h0, gpio_out}, 32'h0);
        chk("rst_mid_ready", {31'h0, hreadyout}, 32'h1);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    localparam logic [1:0] T_IDLE = 2'b00, T_NS = 2'b10;

    initial begin
        int first_one;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, hreadyout}, 32'h1);
        chk("rst_resp", {31'h0, hresp}, 32'h0);
        chk("rst_gpio", {24'h0, gpio_out}, 32'h0);
        rst_n = 1'b1;

        // Reads right after reset release, inputs low.
        cyc(1'b1, T_NS, 1'b0, 32'h0, 32'h0);
        cyc(1'b1, T_NS, 1'b0, 32'h4, 32'h0);
        chk("rd0_ready", {31'h0, o_rdy}, 32'h1);
        chk("rd0_resp", {31'h0, o_rsp}, 32'h0);
        chk("rd0_data", o_rd, 32'h0);
        idle(32'h0);
        chk("rd4_data", o_rd, 32'h0);
        chk("rd4_ready", {31'h0, o_rdy}, 32'h1);

        // Write 0xA5 then back-to-back read.
        cyc(1'b1, T_NS, 1'b1, 32'h0, 32'h0);
        cyc(1'b1, T_NS, 1'b0, 32'h0, 32'h0000_00A5);
        chk("wr_a5_ready", {31'h0, o_rdy}, 32'h1);
        idle(32'h0);
        chk("rd_after_wr", o_rd, 32'h0000_00A5);
        chk("gpio_a5", {24'h0, o_go}, 32'hA5);

        // SET 0x0F then CLR 0x81.
        cyc(1'b1, T_NS, 1'b1, 32'h8, 32'h0);
        cyc(1'b1, T_NS, 1'b1, 32'hC, 32'h0F);
        idle(32'h81);
        chk("gpio_set", {24'h0, o_go}, 32'hAF);
        idle(32'h0);
        chk("gpio_clr", {24'h0, o_go}, 32'h2E);

        // Unmapped read, then an immediate NONSEQ read of DATA_OUT.
        cyc(1'b1, T_NS, 1'b0, 32'h10, 32'h0);
        cyc(1'b1, T_NS, 1'b0, 32'h0, 32'h0);
        chk("err1_ready", {31'h0, o_rdy}, 32'h0);
        chk("err1_resp", {31'h0, o_rsp}, 32'h1);
        cyc(1'b1, T_NS, 1'b0, 32'h0, 32'h0);
        chk("err2_ready", {31'h0, o_rdy}, 32'h1);
        chk("err2_resp", {31'h0, o_rsp}, 32'h1);
        idle(32'h0);
        chk("post_err_resp", {31'h0, o_rsp}, 32'h0);
        chk("post_err_data", o_rd, 32'h2E);

        // Unmapped write must not touch DATA_OUT; DATA_IN write ignored.
        cyc(1'b1, T_NS, 1'b1, 32'h14, 32'h0);
        cyc(1'b0, T_IDLE, 1'b0, 32'h0, 32'hFF);
        cyc(1'b1, T_NS, 1'b1, 32'h4, 32'hFF);
        cyc(1'b1, T_NS, 1'b0, 32'h8, 32'hFF);
        idle(32'h0);
        chk("rd_set_zero", o_rd, 32'h0);
        chk("unmapped_wr_gpio", {24'h0, o_go}, 32'h2E);

`ifdef GPIO_DEBOUNCE_EN
        // 5-cycle glitch never reaches DATA_IN.
        gpio_in = 8'h01;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, T_NS, 1'b0, 32'h4, 32'h0);
            if (i > 0) chk("db_glitch", o_rd, 32'h0);
        end
        gpio_in = 8'h00;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, T_NS, 1'b0, 32'h4, 32'h0);
            chk("db_glitch", o_rd, 32'h0);
        end
        // Held high: DATA_IN must rise within 2 + 3*N cycles.
        gpio_in = 8'h01;
        first_one = -1;
        for (int i = 0; i < 18; i++) begin
            cyc(1'b1, T_NS, 1'b0, 32'h4, 32'h0);
            if (first_one < 0 && o_rd == 32'h1) first_one = i;
        end
        chk("db_held_rise", {31'h0, (first_one >= 1 && first_one <= 14)}, 32'h1);
`else
        gpio_in = 8'h01;
        cyc(1'b1, T_NS, 1'b0, 32'h4, 32'h0);
        cyc(1'b1, T_NS, 1'b0, 32'h4, 32'h0);
        chk("in_lat1", o_rd, 32'h0);
        cyc(1'b1, T_NS, 1'b0, 32'h4, 32'h0);
        chk("in_lat2", o_rd, 32'h1);
        first_one = 0;
`endif
        idle(32'h0);

        // Reset during a write data phase.
        cyc(1'b1, T_NS, 1'b1, 32'h0, 32'h0);
        reset_mid_cycle(32'h5A);
        idle(32'h0);
        idle(32'h0);
        chk("no_late_update", {24'h0, o_go}, 32'h0);
        cyc(1'b1, T_NS, 1'b1, 32'h0, 32'h0);
        idle(32'h3C);
        idle(32'h0);
        chk("post_rst_write", {24'h0, o_go}, 32'h3C);

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 7) == 0) gpio_in = 8'($urandom);
            a = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hF);
            cyc(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 1'($urandom),
                a, $urandom);
            if ($urandom_range(0, 399) == 0) reset_mid_cycle($urandom);
        end
        idle(32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ahb3lite_gpio.md
AHB3LITE_GPIO -- requirements
Module: ahb3lite_gpio

Interface
REQ-001 Parameter g_haddr_width, default 32, AHB address width.
REQ-002 Parameter g_hdata_width, default 32, AHB data width (only 32 supported).
REQ-003 Parameter g_debounce_cycles, default 10000, hclk cycles per debounce sample tick (>=2).
REQ-004 hclk_i  in  1  AHB clock, single clock domain.
REQ-005 hreset_n_i  in  1  asynchronous, active-low reset.
REQ-006 hsel_i  in  1  slave select from interconnect.
REQ-007 haddr_i  in  g_haddr_width  transfer address; only bits [3:2] decoded, plus bits [g_haddr_width-1:4] for the unmapped check.
REQ-008 htrans_i  in  2  IDLE/BUSY/NONSEQ/SEQ.
REQ-009 hwrite_i  in  1  1 = write.
REQ-010 hsize_i, hburst_i, hprot_i, hmastlock_i  in  3, 3, 4, 1  accepted and ignored.
REQ-011 hwdata_i  in  32  write data, data phase.
REQ-012 hready_i  in  1  bus-wide HREADY; address phase sampled only when high.
REQ-013 hrdata_o  out  32  read data, data phase.
REQ-014 hreadyout_o  out  1  slave ready.
REQ-015 hresp_o  out  1  0 = OKAY, 1 = ERROR.
REQ-016 gpio_i  in  8  asynchronous inputs (push buttons).
REQ-017 gpio_o  out  8  registered outputs (LEDs).

Function
REQ-018 Address phase SHALL be captured when hsel_i & hready_i & htrans_i[1]; IDLE and BUSY transfers get a zero-wait OKAY response.
REQ-019 Register map: 0x0 DATA_OUT (R/W, bits [7:0]); 0x4 DATA_IN (RO); 0x8 SET (WO, 1 sets DATA_OUT bit); 0xC CLR (WO, 1 clears DATA_OUT bit); unused bits read 0.
REQ-020 Valid accesses SHALL be zero-wait: hreadyout_o = 1 and hresp_o = 0 in the data phase.
REQ-021 A write SHALL take hwdata_i[7:0] in its data phase and update DATA_OUT/gpio_o on the clock edge that ends that phase.
REQ-022 A read issued right after a write SHALL return the post-write value.
REQ-023 Writes to DATA_IN SHALL be ignored with OKAY; reads of SET/CLR SHALL return 0x0.
REQ-024 An access with haddr_i[g_haddr_width-1:4] != 0 SHALL get a two-cycle ERROR: cycle 1 hreadyout_o = 0, hresp_o = 1; cycle 2 hreadyout_o = 1, hresp_o = 1; no register change.
REQ-025 The response FSM SHALL have states IDLE -> ERR1 -> ERR2 -> IDLE; ERR2 may go directly to ERR1 if another unmapped transfer is accepted.
REQ-026 gpio_i SHALL pass through a 2-FF synchronizer before any use.
REQ-027 hrdata_o SHALL be driven from the data-phase register select combinationally and SHALL be 0 outside read data phases.

Reset
REQ-028 On hreset_n_i low: DATA_OUT = 0x00, gpio_o = 0x00, hreadyout_o = 1, hresp_o = 0, FSM = IDLE, synchronizers and debounce state = 0.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer; the register is not updated.
REQ-030 After release, the first transfer SHALL be accepted on the first qualifying edge.

Configuration
REQ-031 Macro GPIO_DEBOUNCE_EN defined:
  - a prescaler counter wraps every g_debounce_cycles and emits a one-cycle tick;
  - a DATA_IN bit changes only after 3 consecutive ticks sample the same synchronized value;
  - the counter restarts at 0 on wrap.
REQ-032 Macro GPIO_DEBOUNCE_EN undefined: DATA_IN equals the synchronizer output (2-cycle latency) and no prescaler logic is instantiated.

Verification
REQ-033 Reset, then read 0x0 and 0x4 with inputs low -> 0x00, 0x00, OKAY, zero wait.
REQ-034 Write 0xA5 to 0x0, then back-to-back read 0x0 -> gpio_o = 0xA5 one edge after the data phase, read returns 0x000000A5.
REQ-035 From DATA_OUT = 0xA5: write 0x0F to 0x8, then 0x81 to 0xC -> gpio_o = 0xAF, then 0x2E.
REQ-036 Read 0x10 followed immediately by a NONSEQ read of 0x0 -> ERROR pattern (0/1, 1/1), then OKAY with DATA_OUT; DATA_OUT unchanged.
REQ-037 Debounce, GPIO_DEBOUNCE_EN set, g_debounce_cycles = 4:
  - gpio_i[0] glitch high for 5 cycles -> DATA_IN stays 0x00;
  - held high -> DATA_IN = 0x01 within 2 + 3x4 cycles.
  Same stimulus without the macro -> DATA_IN = 0x01 after 2 cycles.
REQ-038 Assert hreset_n_i during a write data phase -> gpio_o = 0x00 and no late update after release.
